// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_d_out,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic [15:0] served0,
  output logic [15:0] served1
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic       ptr, gnt, sel, accept, hs0, hs1, illegal;
  // Both valid: pointer holder wins; otherwise whoever is valid wins
  assign sel        = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign req0_ready = state == IDLE && req0_valid && !sel;
  assign req1_ready = state == IDLE && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign hs0        = rsp0_valid && rsp0_ready;
  assign hs1        = rsp1_valid && rsp1_ready;
  assign illegal    = alu_op[2] && alu_op[1];
  // Transaction sequencing: accept, one ALU cycle, then hold the response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (hs0 || hs1) state <= IDLE;
        default: state <= IDLE;
      endcase
  // Operand registers double as the ALU drive and hold between transactions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_op    <= '0;
      gnt       <= 1'b0;
    end else if (accept) begin
      alu_data1 <= sel ? req1_data1 : req0_data1;
      alu_data2 <= sel ? req1_data2 : req0_data2;
      alu_op    <= sel ? req1_op : req0_op;
      gnt       <= sel;
    end
  // Capture the ALU result at the end of EXEC, masking it for illegal opcodes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp0_valid <= !gnt;
      rsp1_valid <= gnt;
      rsp_data   <= illegal ? '0 : alu_d_out;
      rsp_zero   <= !illegal && alu_zero;
      rsp_ovf    <= !illegal && alu_ovf;
      rsp_err    <= illegal;
    end else if (hs0 || hs1) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end
  // Priority pointer flips on every completed response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (hs0 || hs1) ptr <= !ptr;
  // Saturating per-requester completion counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      served0 <= '0;
      served1 <= '0;
    end else begin
      if (hs0 && served0 != '1) served0 <= served0 + 16'd1;
      if (hs1 && served1 != '1) served1 <= served1 + 16'd1;
    end
endmodule
